fifo_word_reader: RTL

Consumer-side controller for the byte FIFO. It pops 8-bit entries through the FIFO read interface (read_ctrl, read_data, is_empty) and packs them little-endian into BYTES_PER_WORD-byte words. Each word is presented on a valid/ready output port. It sits between the fifo instance and any word-wide consumer, and supports a flush that emits a trailing partial word once the FIFO is drained.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_word_reader.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and types for the byte FIFO and its
//                consumer-side word reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   // Width of one FIFO entry
   localparam int BYTE_W = 8;

   // Word reader states: collecting bytes, or presenting a word downstream
   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } reader_state_e;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_word_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_word_reader
//  Description : Pops bytes from the byte FIFO and packs them little-endian
//                into BYTES_PER_WORD-byte words on a valid/ready port. A
//                level flush emits a trailing partial word once the FIFO
//                has drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_word_reader
   import fifo_pkg::*;
#(
   parameter int BYTES_PER_WORD = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [BYTE_W-1:0]                  fifo_read_data,
   input  logic                               fifo_is_empty,
   output logic                               fifo_read_ctrl,
   input  logic                               flush,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [BYTE_W*BYTES_PER_WORD-1:0]   out_data,
   output logic [BYTES_PER_WORD-1:0]          out_byte_en,
   output logic                               busy
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

   // Lane index of the byte that completes a full word
   localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

   typedef logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] lanes_t;

   reader_state_e              state_q,     state_d;
   logic [CNT_W-1:0]           count_q,     count_d;
   lanes_t                     lanes_q,     lanes_d;
   logic [BYTES_PER_WORD-1:0]  byte_en_q,   byte_en_d;
   logic                       out_valid_q, out_valid_d;

   logic                       w_pop;

   // State register: all reader state, cleared asynchronously so a partial
   // word in flight is simply discarded
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FILL;
         count_q     <= '0;
         lanes_q     <= '0;
         byte_en_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         lanes_q     <= lanes_d;
         byte_en_q   <= byte_en_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Next-state: lane loading, word completion, flush and handshake
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      lanes_d     = lanes_q;
      byte_en_d   = byte_en_q;
      out_valid_d = out_valid_q;

      case (state_q)
         FILL: begin
            if (w_pop) begin
               // Write the head byte into the lane selected by count
               for (int i = 0; i < BYTES_PER_WORD; i++) begin
                  if (count_q == CNT_W'(i)) begin
                     lanes_d[i]   = fifo_read_data;
                     byte_en_d[i] = 1'b1;
                  end
               end
               if (count_q == c_LAST_IDX) begin
                  state_d     = HOLD;
                  out_valid_d = 1'b1;
                  count_d     = '0;
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end else if (flush && (count_q != '0)) begin
               // FIFO drained with a partial word pending: ship it as is.
               // Lanes above count were cleared earlier, so they read 0.
               state_d     = HOLD;
               out_valid_d = 1'b1;
               count_d     = '0;
            end
         end

         HOLD: begin
            // Word is frozen until accepted; flush has no effect here
            if (out_ready) begin
               state_d     = FILL;
               out_valid_d = 1'b0;
               lanes_d     = '0;
               byte_en_d   = '0;
               count_d     = '0;
               if (w_pop) begin
                  // Byte popped on the handshake cycle starts the next word
                  lanes_d[0]   = fifo_read_data;
                  byte_en_d[0] = 1'b1;
                  count_d      = CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = FILL;
         end
      endcase
   end

   // Pop decision: never when empty, never while a word is stalled, and
   // never during reset
   always_comb begin
      w_pop = 1'b0;
      if (rst && !fifo_is_empty) begin
         w_pop = (state_q == FILL) || ((state_q == HOLD) && out_ready);
      end
   end

   // Outputs are direct register views apart from the pop strobe
   assign fifo_read_ctrl = w_pop;
   assign out_valid      = out_valid_q;
   assign out_data       = lanes_q;
   assign out_byte_en    = byte_en_q;
   assign busy           = (count_q != '0) || out_valid_q;

   // Pop strobe only with data available
   a_pop_nonempty : assert property (@(posedge clk) disable iff (!rst)
      fifo_read_ctrl |-> !fifo_is_empty);

   // Presented word is frozen while stalled
   a_hold_stable : assert property (@(posedge clk) disable iff (!rst)
      (out_valid && !out_ready) |=> $stable({out_data, out_byte_en}));

   // No empty word is ever presented
   a_no_empty_word : assert property (@(posedge clk) disable iff (!rst)
      out_valid |-> (out_byte_en != '0));

endmodule : fifo_word_reader
`default_nettype wire
